multicycle_control_fsm: RTL and testbench

Main sequencer for the multicycle RV32I core: a Moore/Mealy state machine that steps each instruction through fetch, decode, execute, memory and writeback over 3–5+ cycles. It drives the shared ALU, single unified memory port, instruction/PC registers and register file. It replaces the single-cycle decoder's one-shot control. Instruction fields come from the instruction register, which is stable from DECODE until the next FETCH completes.

---
 rtl/multicycle_control_fsm_if.sv | 35 +++
 rtl/multicycle_control_fsm.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle sequencer and the datapath/memory port.
// master is the sequencer side, slave the datapath side.
interface multicycle_control_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic       mem_ready;

  logic       mem_req;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUctrl;
  logic [2:0] ImmSrc;
  logic       retire;
  logic       illegal_instr;

  modport master (
    input  op, funct3, funct7, Zero, mem_ready,
    output mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, retire, illegal_instr
  );

  modport slave (
    output op, funct3, funct7, Zero, mem_ready,
    input  mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUctrl, ImmSrc, retire, illegal_instr
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multicycle RV32I core: steps each instruction through
// fetch/decode/execute/memory/writeback and drives the shared datapath controls.
module multicycle_control_fsm (
  input logic                  clk,
  input logic                  rst,
  multicycle_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StExecI    = 4'd8,
    StJal      = 4'd9,
    StBranch   = 4'd10,
    StTrap     = 4'd11
  } state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluSlt = 3'b101;

  localparam logic [2:0] ImmI = 3'b000;
  localparam logic [2:0] ImmS = 3'b001;
  localparam logic [2:0] ImmB = 3'b010;
  localparam logic [2:0] ImmJ = 3'b100;

  state_e state_q, state_d;

  logic       mem_req_c, irwrite_c, pcwrite_c, memwrite_c, regwrite_c, retire_c;
  logic       adrsrc_c;
  logic [1:0] resultsrc_c, srca_c, srcb_c;
  logic [2:0] aluctrl_c, immsrc_c;
  logic       alu_legal;
  logic [2:0] alu_sel;

  // Shared funct3 -> ALU op mapping; sub only applies to R-type (gated by caller).
  always_comb begin
    alu_legal = 1'b1;
    alu_sel   = AluAdd;
    unique case (bus.funct3)
      3'b000:  alu_sel = AluAdd;
      3'b111:  alu_sel = AluAnd;
      3'b110:  alu_sel = AluOr;
      3'b010:  alu_sel = AluSlt;
      default: alu_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req_c   = 1'b0;
    adrsrc_c    = 1'b0;
    irwrite_c   = 1'b0;
    pcwrite_c   = 1'b0;
    memwrite_c  = 1'b0;
    regwrite_c  = 1'b0;
    retire_c    = 1'b0;
    resultsrc_c = 2'b00;
    srca_c      = 2'b00;
    srcb_c      = 2'b00;
    aluctrl_c   = AluAdd;
    immsrc_c    = ImmI;

    unique case (state_q)
      StFetch: begin
        mem_req_c   = 1'b1;
        srcb_c      = 2'b10;
        resultsrc_c = 2'b10;
        irwrite_c   = bus.mem_ready;
        pcwrite_c   = bus.mem_ready;
        if (bus.mem_ready) state_d = StDecode;
      end
      StDecode: begin
        // Precompute branch/jal target into ALUOut while decoding.
        srca_c = 2'b01;
        srcb_c = 2'b01;
        case (bus.op)
          OpStore:  immsrc_c = ImmS;
          OpBranch: immsrc_c = ImmB;
          OpJal:    immsrc_c = ImmJ;
          default:  immsrc_c = ImmI;
        endcase
        state_d = StTrap;
        case (bus.op)
          OpLoad, OpStore: if (bus.funct3 == 3'b010) state_d = StMemAdr;
          OpRType:         state_d = StExecR;
          OpIType:         if (alu_legal) state_d = StExecI;
          OpBranch:        if (bus.funct3[2:1] == 2'b00) state_d = StBranch;
          OpJal:           state_d = StJal;
          default:         state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        srca_c   = 2'b10;
        srcb_c   = 2'b01;
        immsrc_c = (bus.op == OpStore) ? ImmS : ImmI;
        state_d  = (bus.op == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_req_c = 1'b1;
        adrsrc_c  = 1'b1;
        if (bus.mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        resultsrc_c = 2'b01;
        regwrite_c  = 1'b1;
        retire_c    = 1'b1;
        state_d     = StFetch;
      end
      StMemWrite: begin
        mem_req_c  = 1'b1;
        adrsrc_c   = 1'b1;
        memwrite_c = bus.mem_ready;
        retire_c   = bus.mem_ready;
        if (bus.mem_ready) state_d = StFetch;
      end
      StExecR: begin
        srca_c    = 2'b10;
        aluctrl_c = (bus.funct3 == 3'b000 && bus.funct7) ? AluSub : alu_sel;
        state_d   = alu_legal ? StAluWb : StTrap;
      end
      StExecI: begin
        srca_c    = 2'b10;
        srcb_c    = 2'b01;
        aluctrl_c = alu_sel;
        state_d   = StAluWb;
      end
      StAluWb: begin
        regwrite_c = 1'b1;
        retire_c   = 1'b1;
        state_d    = StFetch;
      end
      StJal: begin
        // ALU forms the link value while ALUOut (target) goes to PC.
        srca_c    = 2'b01;
        srcb_c    = 2'b10;
        pcwrite_c = 1'b1;
        state_d   = StAluWb;
      end
      StBranch: begin
        srca_c    = 2'b10;
        aluctrl_c = AluSub;
        pcwrite_c = (bus.funct3 == 3'b000 && bus.Zero) || (bus.funct3 == 3'b001 && !bus.Zero);
        retire_c  = 1'b1;
        state_d   = StFetch;
      end
      StTrap: state_d = StTrap;
      default: state_d = StFetch;
    endcase
  end

  assign bus.mem_req       = mem_req_c & ~rst;
  assign bus.IRWrite       = irwrite_c & ~rst;
  assign bus.PCWrite       = pcwrite_c & ~rst;
  assign bus.MemWrite      = memwrite_c & ~rst;
  assign bus.RegWrite      = regwrite_c & ~rst;
  assign bus.retire        = retire_c & ~rst;
  assign bus.AdrSrc        = adrsrc_c;
  assign bus.ResultSrc     = resultsrc_c;
  assign bus.ALUSrcA       = srca_c;
  assign bus.ALUSrcB       = srcb_c;
  assign bus.ALUctrl       = aluctrl_c;
  assign bus.ImmSrc        = immsrc_c;
  assign bus.illegal_instr = (state_q == StTrap);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for the multicycle sequencer: per-cycle stimulus and expected control
// vectors are queued together, then replayed and compared cycle by cycle.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_control_fsm_if bus ();

  multicycle_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic       zero;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
  } stim_t;

  stim_t       stim_q[$];
  logic [19:0] exp_q[$];
  string       tag_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;

  logic [19:0] obs;
  assign obs = {bus.mem_req, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.MemWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUctrl, bus.ImmSrc,
                bus.retire, bus.illegal_instr};

  function automatic logic [19:0] pk(logic mreq, logic adr, logic irw, logic pcw, logic mw,
                                     logic rw, logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                     logic [2:0] alu, logic [2:0] imm, logic ret, logic ill);
    return {mreq, adr, irw, pcw, mw, rw, rs, sa, sb, alu, imm, ret, ill};
  endfunction

  // Expected vectors per state, written straight from the state descriptions.
  function automatic logic [19:0] e_fetch(logic r);
    return pk(1, 0, r, r, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] e_decode(logic [2:0] imm);
    return pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 0, 0);
  endfunction
  function automatic logic [19:0] e_memadr(logic [2:0] imm);
    return pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, imm, 0, 0);
  endfunction
  function automatic logic [19:0] e_memread();
    return pk(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] e_memwb();
    return pk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0);
  endfunction
  function automatic logic [19:0] e_memwrite(logic r);
    return pk(1, 1, 0, 0, r, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, r, 0);
  endfunction
  function automatic logic [19:0] e_execr(logic [2:0] alu);
    return pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] e_execi(logic [2:0] alu);
    return pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] e_aluwb();
    return pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1, 0);
  endfunction
  function automatic logic [19:0] e_jal();
    return pk(0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000, 0, 0);
  endfunction
  function automatic logic [19:0] e_branch(logic pcw);
    return pk(0, 0, 0, pcw, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000, 1, 0);
  endfunction
  function automatic logic [19:0] e_trap();
    return pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 1);
  endfunction

  task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic r, input logic rdy, input logic zero,
                      input logic [19:0] exp);
    stim_t s;
    s.rst  = r;
    s.rdy  = rdy;
    s.zero = zero;
    s.op   = cur_op;
    s.f3   = cur_f3;
    s.f7   = cur_f7;
    stim_q.push_back(s);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    cur_op = op;
    cur_f3 = f3;
    cur_f7 = f7;
  endtask

  task automatic drain();
    stim_t       s;
    logic [19:0] e;
    string       t;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      @(posedge clk);
      #1;
      rst           = s.rst;
      bus.mem_ready = s.rdy;
      bus.Zero      = s.zero;
      bus.op        = s.op;
      bus.funct3    = s.f3;
      bus.funct7    = s.f7;
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, obs, e);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.mem_ready = 1'b1;
    bus.Zero      = 1'b0;
    bus.op        = 7'd0;
    bus.funct3    = 3'd0;
    bus.funct7    = 1'b0;
    repeat (2) @(posedge clk);

    instr(7'b0000000, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++)
      push("reset_hold", 1, 1, 0, pk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0, 0));

    instr(7'b0010011, 3'b000, 1'b0);  // addi
    push("addi_fetch", 0, 1, 0, e_fetch(1));
    push("addi_decode", 0, 1, 0, e_decode(3'b000));
    push("addi_execi", 0, 1, 0, e_execi(3'b000));
    push("addi_aluwb", 0, 1, 0, e_aluwb());

    instr(7'b0000011, 3'b010, 1'b0);  // lw with 2 stall cycles
    push("lw_fetch", 0, 1, 0, e_fetch(1));
    push("lw_decode", 0, 1, 0, e_decode(3'b000));
    push("lw_memadr", 0, 1, 0, e_memadr(3'b000));
    push("lw_memread0", 0, 0, 0, e_memread());
    push("lw_memread1", 0, 0, 0, e_memread());
    push("lw_memread2", 0, 1, 0, e_memread());
    push("lw_memwb", 0, 1, 0, e_memwb());

    instr(7'b1100011, 3'b000, 1'b0);  // beq taken
    push("beq_t_fetch", 0, 1, 0, e_fetch(1));
    push("beq_t_decode", 0, 1, 0, e_decode(3'b010));
    push("beq_t_branch", 0, 1, 1, e_branch(1));
    push("beq_n_fetch", 0, 1, 0, e_fetch(1));
    push("beq_n_decode", 0, 1, 0, e_decode(3'b010));
    push("beq_n_branch", 0, 1, 0, e_branch(0));

    instr(7'b1100011, 3'b001, 1'b0);  // bne
    push("bne_t_fetch", 0, 1, 0, e_fetch(1));
    push("bne_t_decode", 0, 1, 0, e_decode(3'b010));
    push("bne_t_branch", 0, 1, 0, e_branch(1));
    push("bne_n_fetch", 0, 1, 1, e_fetch(1));
    push("bne_n_decode", 0, 1, 1, e_decode(3'b010));
    push("bne_n_branch", 0, 1, 1, e_branch(0));

    instr(7'b0110011, 3'b000, 1'b1);  // sub
    push("sub_fetch", 0, 1, 0, e_fetch(1));
    push("sub_decode", 0, 1, 0, e_decode(3'b000));
    push("sub_execr", 0, 1, 0, e_execr(3'b001));
    push("sub_aluwb", 0, 1, 0, e_aluwb());

    instr(7'b0010011, 3'b000, 1'b1);  // addi with funct7 set: never sub
    push("addif7_fetch", 0, 1, 0, e_fetch(1));
    push("addif7_decode", 0, 1, 0, e_decode(3'b000));
    push("addif7_execi", 0, 1, 0, e_execi(3'b000));
    push("addif7_aluwb", 0, 1, 0, e_aluwb());

    instr(7'b0110011, 3'b111, 1'b0);  // and with fetch stall
    push("and_fetch_stall", 0, 0, 0, e_fetch(0));
    push("and_fetch", 0, 1, 0, e_fetch(1));
    push("and_decode", 0, 1, 0, e_decode(3'b000));
    push("and_execr", 0, 1, 0, e_execr(3'b010));
    push("and_aluwb", 0, 1, 0, e_aluwb());

    instr(7'b0010011, 3'b110, 1'b0);  // ori
    push("ori_fetch", 0, 1, 0, e_fetch(1));
    push("ori_decode", 0, 1, 0, e_decode(3'b000));
    push("ori_execi", 0, 1, 0, e_execi(3'b011));
    push("ori_aluwb", 0, 1, 0, e_aluwb());

    instr(7'b0110011, 3'b010, 1'b0);  // slt
    push("slt_fetch", 0, 1, 0, e_fetch(1));
    push("slt_decode", 0, 1, 0, e_decode(3'b000));
    push("slt_execr", 0, 1, 0, e_execr(3'b101));
    push("slt_aluwb", 0, 1, 0, e_aluwb());

    instr(7'b0100011, 3'b010, 1'b0);  // sw
    push("sw_fetch", 0, 1, 0, e_fetch(1));
    push("sw_decode", 0, 1, 0, e_decode(3'b001));
    push("sw_memadr", 0, 1, 0, e_memadr(3'b001));
    push("sw_memwrite", 0, 1, 0, e_memwrite(1));

    instr(7'b1101111, 3'b000, 1'b0);  // jal
    push("jal_fetch", 0, 1, 0, e_fetch(1));
    push("jal_decode", 0, 1, 0, e_decode(3'b100));
    push("jal_jal", 0, 1, 0, e_jal());
    push("jal_aluwb", 0, 1, 0, e_aluwb());

    instr(7'b0110011, 3'b001, 1'b0);  // R-type with unsupported funct3
    push("rbad_fetch", 0, 1, 0, e_fetch(1));
    push("rbad_decode", 0, 1, 0, e_decode(3'b000));
    push("rbad_execr", 0, 1, 0, e_execr(3'b000));
    push("rbad_trap0", 0, 1, 0, e_trap());
    push("rbad_trap1", 0, 1, 0, e_trap());
    push("rbad_rst", 1, 1, 0, e_trap());

    instr(7'b0110111, 3'b000, 1'b0);  // illegal opcode
    push("ill_fetch", 0, 1, 0, e_fetch(1));
    push("ill_decode", 0, 1, 0, e_decode(3'b000));
    for (int i = 0; i < 10; i++) push("ill_trap", 0, 1, 0, e_trap());
    push("ill_rst", 1, 1, 0, e_trap());

    instr(7'b0100011, 3'b010, 1'b0);  // sw stalled, then reset
    push("swrst_fetch", 0, 1, 0, e_fetch(1));
    push("swrst_decode", 0, 1, 0, e_decode(3'b001));
    push("swrst_memadr", 0, 1, 0, e_memadr(3'b001));
    push("swrst_stall0", 0, 0, 0, e_memwrite(0));
    push("swrst_stall1", 0, 0, 0, e_memwrite(0));
    push("swrst_rst", 1, 1, 0, pk(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0, 0));
    push("swrst_after", 0, 1, 0, e_fetch(1));

    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
